// File: rtl/div_frac_ctrl_pkg.sv
// div_frac_ctrl_pkg: shared state encoding and sizing helper for the divider controller
package div_frac_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_OUT = 2'd2} state_t;
  function automatic int wdog_w(input int cyc);
    return $clog2(cyc + 1);
  endfunction
endpackage

// File: rtl/div_frac_wdog.sv
// div_frac_wdog: loadable up-counter with clear, enable and terminal-count flag
module div_frac_wdog #(
  parameter int W  = 6,
  parameter int TC = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);
  logic [W-1:0] count;
  assign tc = count == W'(TC);
  // clear has priority over load, load over counting
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (load) count <= load_val;
    else if (en) count <= count + 1'b1;
endmodule

// File: rtl/div_frac_ctrl.sv
// div_frac_ctrl: valid/ready front-end and result stage for the shift-subtract divider
module div_frac_ctrl
  import div_frac_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int WDOG_CYC = DATA_W + 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [DATA_W-1:0] in_dividend,
  input  logic [DATA_W-1:0] in_divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_quotient,
  output logic              out_dbz,
  output logic              out_err,
  output logic              div_en,
  output logic              div_sign,
  output logic [DATA_W-1:0] div_dividend,
  output logic [DATA_W-1:0] div_divisor,
  input  logic              div_done,
  input  logic [DATA_W-1:0] div_quotient
);
  localparam int WW = wdog_w(WDOG_CYC);
  state_t state, state_nxt;
  logic accept, wd_tc, dbz;
  assign accept = in_valid && in_ready;
  assign dbz = in_divisor == '0;
  // The counter is loaded with 1 on accept so it holds the number of div_en cycles seen so far
  div_frac_wdog #(.W(WW), .TC(WDOG_CYC)) u_wdog (
    .clk(clk),
    .rst(rst),
    .clr(out_valid),
    .load(accept),
    .load_val(WW'(1)),
    .en(div_en),
    .tc(wd_tc)
  );
  // state register; async reset drops div_en at once
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_nxt;
  // next state and state-decoded handshake/enable outputs
  always_comb begin
    in_ready = state == ST_IDLE;
    div_en = state == ST_RUN;
    out_valid = state == ST_OUT;
    state_nxt = state;
    if (in_valid && state == ST_IDLE) state_nxt = dbz ? ST_OUT : ST_RUN;
    else if (state == ST_RUN && (div_done || wd_tc)) state_nxt = ST_OUT;
    else if (state == ST_OUT && out_ready) state_nxt = ST_IDLE;
  end
  // holding registers for divider pins and result; only written on accept or RUN exit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div_sign <= 1'b0;
      div_dividend <= '0;
      div_divisor <= '0;
      out_quotient <= '0;
      out_dbz <= 1'b0;
      out_err <= 1'b0;
    end else if (accept) begin
      div_sign <= in_sign;
      div_dividend <= in_dividend;
      div_divisor <= in_divisor;
      out_quotient <= dbz ? '1 : '0;
      out_dbz <= dbz;
      out_err <= 1'b0;
    end else if (div_en && (div_done || wd_tc)) begin
      out_quotient <= div_done ? div_quotient : '0;
      out_dbz <= 1'b0;
      out_err <= !div_done;
    end
endmodule

// File: tb/tb_div_frac_ctrl.sv
// tb_div_frac_ctrl: scoreboard bench with a latency-programmable divider stub
module tb_div_frac_ctrl;
  typedef struct {
    logic s;
    logic [31:0] dd, dv, q;
    logic dbz, err;
    int lat, en, acc;
  } exp_t;
  logic clk = 0, rst = 0;
  logic in_valid = 0, in_sign = 0, out_ready = 1;
  logic [31:0] in_dividend = 0, in_divisor = 0;
  logic in_ready, out_valid, out_dbz, out_err, div_en, div_sign, div_done;
  logic [31:0] out_quotient, div_dividend, div_divisor, div_quotient;
  int checks = 0, failures = 0, cyc = 0;
  exp_t sb[$];
  exp_t cur;
  logic prev_ov = 0;
  int en_cnt = 0;
  int stub_lat = 36;
  logic stub_hang = 0;
  logic [31:0] stub_q = 32'h0000_1234;
  int stub_cnt = 0;

  div_frac_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .out_valid(out_valid), .out_ready(out_ready), .out_quotient(out_quotient),
    .out_dbz(out_dbz), .out_err(out_err),
    .div_en(div_en), .div_sign(div_sign), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_done(div_done), .div_quotient(div_quotient)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // divider stub: done on its stub_lat-th enabled cycle, counter restarts whenever en drops
  always @(posedge clk) stub_cnt <= div_en ? stub_cnt + 1 : 0;
  assign div_done = div_en && !stub_hang && stub_cnt == stub_lat - 1;
  assign div_quotient = stub_q;

  function automatic void chk(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  // monitor: pin routing during RUN, result/latency on out_valid rise, hold while stalled
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 0;
      en_cnt = 0;
    end else begin
      if (div_en) begin
        en_cnt++;
        if (sb.size() == 0) chk("en_without_op", 1, 0);
        else chk("div_pins", {div_sign, div_dividend, div_divisor}, {sb[0].s, sb[0].dd, sb[0].dv});
      end
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          cur = sb.pop_front();
          chk("result", {out_quotient, out_dbz, out_err}, {cur.q, cur.dbz, cur.err});
          chk("latency", cyc + 1 - cur.acc, cur.lat);
          chk("en_cycles", en_cnt, cur.en);
          chk("en_low_in_out", div_en, 0);
        end
        en_cnt = 0;
      end else if (out_valid) chk("hold", {out_quotient, out_dbz, out_err}, {cur.q, cur.dbz, cur.err});
      prev_ov = out_valid;
    end
  end

  task automatic send(input logic s, input logic [31:0] dd, input logic [31:0] dv,
                      input logic [31:0] q, input logic dbz, input logic err, input int lat, input int en);
    exp_t e;
    in_sign = s;
    in_dividend = dd;
    in_divisor = dv;
    in_valid = 1;
    for (int i = 0; i < 300 && !in_ready; i++) @(negedge clk);
    if (!in_ready) chk("accept_timeout", 0, 1);
    else begin
      chk("en_low_at_accept", div_en, 0);
      e = '{s: s, dd: dd, dv: dv, q: q, dbz: dbz, err: err, lat: lat, en: en, acc: cyc + 1};
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1 rst = 1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {out_valid, out_quotient, out_dbz, out_err, div_en, div_sign, div_dividend, div_divisor}, 0);
    rst = 0;
    @(negedge clk);
    chk("ready_after_reset", {in_ready, out_valid, div_en}, 3'b100);
    send(0, 32'h0064_0000, 32'h0003_0000, 32'h0000_1234, 0, 0, 37, 36);
    wait_empty();
    send(0, 32'h0000_0064, 32'h0, 32'hFFFF_FFFF, 1, 0, 1, 0);
    wait_empty();
    send(1, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 1, 0, 1, 0);
    wait_empty();
    stub_hang = 1;
    send(0, 32'h1111_1111, 32'h2222_2222, 32'h0, 0, 1, 41, 40);
    wait_empty();
    stub_hang = 0;
    stub_lat = 40;
    stub_q = 32'h0BAD_F00D;
    send(1, 32'hFFFF_FF00, 32'h0000_0010, 32'h0BAD_F00D, 0, 0, 41, 40);
    wait_empty();
    stub_lat = 1;
    stub_q = 32'h7FFF_FFFF;
    send(0, 32'h0000_0001, 32'h0000_0002, 32'h7FFF_FFFF, 0, 0, 2, 1);
    wait_empty();
    stub_lat = 36;
    stub_q = 32'h0000_ABCD;
    out_ready = 0;
    send(0, 32'h0000_1000, 32'h0000_0300, 32'h0000_ABCD, 0, 0, 37, 36);
    fork
      begin
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        chk("stall_out_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1;
      end
    join_none
    send(1, 32'h4000_0000, 32'hC000_0000, 32'h0000_ABCD, 0, 0, 37, 36);
    wait_empty();
    stub_q = 32'h0000_1234;
    send(0, 32'h0000_0500, 32'h0000_0007, 32'h0000_1234, 0, 0, 37, 36);
    repeat (10) @(negedge clk);
    rst = 1;
    #1 chk("rst_drops_en", {div_en, out_valid}, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (50) @(negedge clk);
    chk("no_result_after_rst", out_valid, 0);
    stub_q = 32'h0000_5A5A;
    send(1, 32'h0000_0900, 32'h0000_0030, 32'h0000_5A5A, 0, 0, 37, 36);
    wait_empty();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
